iommu_queue_push_arb: RTL and testbench
=======================================

# iommu_queue_push_arb

Round-robin arbiter that shares the single push port of one IOMMU queue FIFO (`fifo_v3`, non-fall-through) between `NUM_REQ` producers, e.g. the translation, page-walk and command-processing fault sources.
- Grants at most one producer per cycle, and only while the FIFO is not full.
- Sequences queue flushes: quiesce grants, pulse the FIFO flush, confirm the FIFO is empty, then handshake completion back to software-facing logic.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers; must be 2..16.
- `DATA_WIDTH`, 32: payload width; must match the FIFO.
- `DEPTH`, 8: FIFO depth; used only for the usage-based guard.
- `ADDR_DEPTH`, `(DEPTH>1)?$clog2(DEPTH):1`: derived, never overridden.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  NUM_REQ  per-producer push request.
- `data_i`  in  NUM_REQ*DATA_WIDTH  packed payloads; producer k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt_o`  out  NUM_REQ  one-hot-or-zero grant; a grant means the payload was pushed this cycle.
- `flush_req_i`  in  1  level request to flush the queue.
- `flush_done_o`  out  1  one-cycle pulse when the flush completes.
- `fifo_push_o`  out  1  to FIFO `push_i`.
- `fifo_data_o`  out  DATA_WIDTH  to FIFO `data_i`.
- `fifo_flush_o`  out  1  to FIFO `flush_i`.
- `fifo_full_i`  in  1  from FIFO `full_o`.
- `fifo_empty_i`  in  1  from FIFO `empty_o`.
- `fifo_usage_i`  in  ADDR_DEPTH  from FIFO `usage_o`.

## Operation
FSM states: `RUN`, `FLUSH`, `FLUSH_WAIT`.
- **RUN → FLUSH:** when `flush_req_i`=1. Requests are not granted in that cycle.
- **FLUSH:**
  - `fifo_flush_o`=1 for exactly one cycle.
  - No grants.
  - Always moves to `FLUSH_WAIT`.
- **FLUSH_WAIT:**
  - No grants.
  - When `fifo_empty_i`=1: `flush_done_o`=1 for one cycle, then go to `RUN`.
  - Returning to `RUN` requires `flush_req_i` to have dropped. If it is still high, stay in `FLUSH_WAIT` with `flush_done_o` pulsing only once.

Arbitration (`RUN` only):
- Eligible when `!fifo_full_i` and `|req_i`.
- Winner is the first set `req_i` bit scanning upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
- On a grant to k: `rr_ptr` ← (k+1) mod `NUM_REQ`. On no grant, `rr_ptr` holds.
- `fifo_push_o` = `|gnt_o`.
- `fifo_data_o` = the winner's payload. When there is no grant it is driven as 0, never X.
- The arbiter never pushes while `fifo_full_i`=1, even if the FIFO is popping the same cycle. This keeps it compliant with the FIFO's no-push-when-full rule.

Producer rule:
- Hold `req_i` and payload stable until granted.
- Dropping a request without a grant is legal. It does not move `rr_ptr`.

## Timing
- Grant is combinational: same cycle as `req_i`, zero latency from `fifo_full_i`.
- Data reaches the FIFO output earliest 1 cycle after the grant (non-fall-through FIFO).
- Flush latency: from `flush_req_i` rising in `RUN` to `flush_done_o` is at least 3 cycles: FLUSH (1 cycle), FLUSH_WAIT sampling empty (≥1 cycle), then the done pulse.
- Reset values:
  - state `RUN`, `rr_ptr`=0.
  - `gnt_o`=0, `fifo_push_o`=0, `fifo_data_o`=0.
  - `fifo_flush_o`=0, `flush_done_o`=0.
  - stats counters 0.
- Reset asserted mid-flush aborts it. `flush_done_o` is not pulsed, and the block restarts in `RUN`.
- `fifo_usage_i` is checked only by an internal assertion: a push never occurs when usage == DEPTH-1 and `fifo_full_i`=1.

## Configuration
- `IOMMU_ARB_STATS_EN` defined:
  - Adds output `grant_cnt_o`, width NUM_REQ*16.
  - One 16-bit saturating grant counter per producer. It increments on each `gnt_o[k]`, stays at 0xFFFF, and clears on reset and on entry to `FLUSH`.
- Undefined: the port and the counters are absent. All other behaviour is identical.

## Structure
- Shared package `iommu_arb_pkg` holds:
  - the state enum `arb_state_e` (RUN, FLUSH, FLUSH_WAIT);
  - the constant `ARB_CNT_W`=16.
- One sub-module, `iommu_rr_pick`: combinational, takes `req` and `ptr`, returns a one-hot winner. It is reused by other queue arbiters.
- Packing and unpacking of `data_i` stays in the top module.

## Test plan
- **Single producer:** req_i=4'b0100, data=0xA5A5_0002, FIFO empty → gnt_o=4'b0100 same cycle, fifo_push_o=1, FIFO `data_o`=0xA5A5_0002 next cycle.
- **Fairness:** all four requesting continuously for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3.
- **Full back-pressure:** fifo_full_i=1 with req_i=4'b1111 → gnt_o=0, fifo_push_o=0, rr_ptr unchanged. Full drops → grant resumes at the saved pointer.
- **Flush with 5 entries queued:** pulse flush_req_i for 1 cycle → fifo_flush_o=1 in cycle +1, no grants, flush_done_o=1 in cycle +3, FIFO empty.
- **Flush held high for 6 cycles:** → flush_done_o pulses once, RUN is re-entered only after flush_req_i=0.
- **Async reset asserted in FLUSH_WAIT:** → all outputs 0 immediately, flush_done_o never pulses, rr_ptr=0. With `IOMMU_ARB_STATS_EN`: counters read 0.

Source files
------------

// File: rtl/iommu_queue_push_arb_pkg.sv
// Shared types for the IOMMU queue push arbiters: FSM state encoding,
// grant-counter width and the saturating increment used by the stats counters.
package iommu_arb_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    FLUSH_WAIT = 2'd2
  } arb_state_e;

  localparam int ARB_CNT_W = 16;

  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/iommu_queue_push_arb_if.sv
// Push-side connection between a queue arbiter (master) and its fifo_v3 (slave).
interface iommu_queue_push_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic [ADDR_DEPTH-1:0] usage;

  modport master (output push, data, flush, input full, empty, usage);
  modport slave  (input push, data, flush, output full, empty, usage);
endinterface

// File: rtl/iommu_queue_push_arb_rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first set request
// found scanning upward from i_ptr, wrapping modulo NUM_REQ.
module iommu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iommu_queue_push_arb.sv
// Round-robin arbiter sharing one IOMMU queue FIFO push port, with flush sequencing.
// Optional per-producer saturating grant counters: define IOMMU_ARB_STATS_EN.
module iommu_queue_push_arb
  import iommu_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic                          flush_req_i,
  output logic                          flush_done_o,
`ifdef IOMMU_ARB_STATS_EN
  output logic [NUM_REQ*ARB_CNT_W-1:0]  grant_cnt_o,
`endif
  iommu_queue_push_arb_if.master        fifo
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e            r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_fifo_flush;
  logic                  r_flush_done;
  logic                  r_done_sent;

  logic                  w_arb_en;
  logic [NUM_REQ-1:0]    w_pick;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [DATA_WIDTH-1:0] w_data;
  logic [PTR_W-1:0]      w_ptr_nxt;

  // Grants are also masked by reset so every output reads 0 while rst_i is high.
  assign w_arb_en = (r_state == RUN) && !flush_req_i && !fifo.full && !rst_i;

  iommu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req (req_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );

  assign w_gnt = w_arb_en ? w_pick : '0;

  always_comb begin
    w_data    = '0;
    w_ptr_nxt = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_data    = w_data | data_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_ptr_nxt = PTR_W'((k + 1) % NUM_REQ);
      end
    end
  end

  assign gnt_o        = w_gnt;
  assign fifo.push    = |w_gnt;
  assign fifo.data    = w_data;
  assign fifo.flush   = r_fifo_flush;
  assign flush_done_o = r_flush_done;

  // r_done_sent keeps the done pulse single while flush_req_i is held high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= RUN;
      r_rr_ptr     <= '0;
      r_fifo_flush <= 1'b0;
      r_flush_done <= 1'b0;
      r_done_sent  <= 1'b0;
    end else begin
      r_fifo_flush <= 1'b0;
      r_flush_done <= 1'b0;
      if (|w_gnt) r_rr_ptr <= w_ptr_nxt;
      unique case (r_state)
        RUN: begin
          if (flush_req_i) begin
            r_state      <= FLUSH;
            r_fifo_flush <= 1'b1;
          end
        end
        FLUSH: begin
          r_state     <= FLUSH_WAIT;
          r_done_sent <= 1'b0;
        end
        FLUSH_WAIT: begin
          if (!r_done_sent) begin
            if (fifo.empty) begin
              r_flush_done <= 1'b1;
              if (flush_req_i) r_done_sent <= 1'b1;
              else             r_state     <= RUN;
            end
          end else if (!flush_req_i) begin
            r_state     <= RUN;
            r_done_sent <= 1'b0;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef IOMMU_ARB_STATS_EN
  logic [ARB_CNT_W-1:0] r_cnt [NUM_REQ];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) r_cnt[k] <= '0;
    end else if (r_state == RUN && flush_req_i) begin
      for (int k = 0; k < NUM_REQ; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (w_gnt[k]) r_cnt[k] <= sat_inc(r_cnt[k]);
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < NUM_REQ; k++) grant_cnt_o[k*ARB_CNT_W +: ARB_CNT_W] = r_cnt[k];
  end
`endif

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo.push && fifo.full && (fifo.usage == ADDR_DEPTH'(DEPTH - 1))));

endmodule

// File: tb/tb_iommu_queue_push_arb.sv
// Scoreboard bench for iommu_queue_push_arb with a behavioural counting FIFO.
module tb_iommu_queue_push_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int D  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]    gnt;
  logic            flush_req = 1'b0;
  logic            flush_done;
`ifdef IOMMU_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  iommu_queue_push_arb_if #(.DATA_WIDTH(DW), .DEPTH(D)) fifo_if ();

  iommu_queue_push_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .data_i       (data),
    .gnt_o        (gnt),
    .flush_req_i  (flush_req),
    .flush_done_o (flush_done),
`ifdef IOMMU_ARB_STATS_EN
    .grant_cnt_o  (grant_cnt),
`endif
    .fifo         (fifo_if)
  );

  // Behavioural FIFO occupancy: push/pop/flush, with an external full override.
  int   cnt;
  logic pop_en = 1'b1;
  logic force_full = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= 0;
    else if (fifo_if.flush) cnt <= 0;
    else                    cnt <= cnt + int'(fifo_if.push) - int'(pop_en && cnt > 0);
  end

  assign fifo_if.full  = force_full || (cnt == D);
  assign fifo_if.empty = (cnt == 0);
  assign fifo_if.usage = 3'(cnt);

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [DW-1:0] pay(input int k);
    return 32'hA5A5_0000 + 32'(k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic f);
    @(posedge clk);
    #1;
    req       = r;
    flush_req = f;
  endtask

  task automatic expect_push(input int k);
    exp_t e;
    e.gnt  = N'(1 << k);
    e.data = pay(k);
    exp_q.push_back(e);
  endtask

  // Monitor: every push presented to the FIFO must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && fifo_if.push) begin
      if (fifo_if.full) begin
        tests++; fails++;
        $display("FAIL push_while_full: gnt %b", gnt);
      end
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_push: gnt %b data %h, none expected", gnt, fifo_if.data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_gnt", 64'(gnt), 64'(e.gnt));
        chk("sb_data", 64'(fifo_if.data), 64'(e.data));
      end
    end
  end

  int done_pulses;

  initial begin
    for (int k = 0; k < N; k++) data[k*DW +: DW] = pay(k);

    #2;
    chk("reset_gnt",   64'(gnt), 0);
    chk("reset_push",  64'(fifo_if.push), 0);
    chk("reset_data",  64'(fifo_if.data), 0);
    chk("reset_flush", 64'(fifo_if.flush), 0);
    chk("reset_done",  64'(flush_done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single producer 2
    drive(4'b0100, 1'b0);
    expect_push(2);
    @(negedge clk);
    chk("single_gnt",  64'(gnt), 64'(4'b0100));
    chk("single_push", 64'(fifo_if.push), 1);
    drive(4'b0000, 1'b0);

    // fairness from reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b0);
      expect_push(i % 4);
    end

    // back-pressure: move pointer to 2, stall, then resume
    drive(4'b0010, 1'b0);
    expect_push(1);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b0);
      force_full = 1'b1;
      @(negedge clk);
      chk("bp_gnt",  64'(gnt), 0);
      chk("bp_push", 64'(fifo_if.push), 0);
      chk("bp_data", 64'(fifo_if.data), 0);
    end
    drive(4'b1111, 1'b0);
    force_full = 1'b0;
    expect_push(2);
    drive(4'b1111, 1'b0);
    expect_push(3);
    drive(4'b0000, 1'b0);

    // flush with five entries queued
    drive(4'b1111, 1'b0);
    pop_en = 1'b0;
    expect_push(0);
    for (int i = 1; i < 5; i++) begin
      drive(4'b1111, 1'b0);
      expect_push(i % 4);
    end
    drive(4'b1111, 1'b1);
    @(negedge clk);
    chk("pre_flush_usage", 64'(cnt), 5);
    chk("flush_c0_gnt", 64'(gnt), 0);
    drive(4'b1111, 1'b0);
    @(negedge clk);
    chk("flush_c1_fifo_flush", 64'(fifo_if.flush), 1);
    chk("flush_c1_gnt", 64'(gnt), 0);
    drive(4'b1111, 1'b0);
    @(negedge clk);
    chk("flush_c2_fifo_flush", 64'(fifo_if.flush), 0);
    chk("flush_c2_gnt", 64'(gnt), 0);
    chk("flush_c2_done", 64'(flush_done), 0);
    chk("flush_c2_empty", 64'(fifo_if.empty), 1);
    drive(4'b0010, 1'b0);
    expect_push(1);
    @(negedge clk);
    chk("flush_c3_done", 64'(flush_done), 1);
    drive(4'b0000, 1'b0);
    @(negedge clk);
    chk("flush_c4_done", 64'(flush_done), 0);

    // flush request held for six cycles
    done_pulses = 0;
    for (int i = 0; i < 7; i++) begin
      drive(4'b1111, i < 6);
      @(negedge clk);
      chk("hold_gnt", 64'(gnt), 0);
      if (i == 1) chk("hold_fifo_flush", 64'(fifo_if.flush), 1);
      if (flush_done) done_pulses++;
    end
    drive(4'b1111, 1'b0);
    expect_push(2);
    @(negedge clk);
    if (flush_done) done_pulses++;
    chk("hold_done_pulses", 64'(done_pulses), 1);
    drive(4'b0000, 1'b0);

    // async reset while in FLUSH_WAIT
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt",   64'(gnt), 0);
    chk("arst_push",  64'(fifo_if.push), 0);
    chk("arst_data",  64'(fifo_if.data), 0);
    chk("arst_flush", 64'(fifo_if.flush), 0);
    chk("arst_done",  64'(flush_done), 0);
    @(posedge clk);
    #1;
    chk("arst_done_edge", 64'(flush_done), 0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 1'b0);
      @(negedge clk);
      chk("arst_no_done", 64'(flush_done), 0);
    end
`ifdef IOMMU_ARB_STATS_EN
    chk("arst_stats", 64'(|grant_cnt), 0);
`endif
    drive(4'b1111, 1'b0);
    expect_push(0);
    @(negedge clk);
    chk("arst_ptr_gnt", 64'(gnt), 64'(4'b0001));
    drive(4'b0000, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
